// File: rtl/dex_pkg.sv
// Shared opcode, field and decode definitions for the decode/execute pipe.
package dex_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_MOV  = 5'd1,
    OP_CLR  = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_SUB  = 5'd5,
    OP_JMP  = 5'd6,
    OP_HALT = 5'd7
  } dex_op_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int IMM_MSB = 16;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [16:0] imm;
  } dex_instr_t;

  function automatic dex_instr_t dex_decode(input logic [31:0] instr);
    dex_instr_t d;
    d.opcode = instr[OPC_MSB:OPC_LSB];
    d.rd     = instr[RD_MSB:RD_LSB];
    d.rs     = instr[RS_MSB:RS_LSB];
    d.imm    = instr[IMM_MSB:IMM_LSB];
    return d;
  endfunction

  function automatic logic [63:0] sext_imm(input logic [16:0] imm);
    return {{47{imm[16]}}, imm};
  endfunction

  function automatic logic idx_ok(input logic [4:0] idx, input int nreg);
    return int'(idx) < nreg;
  endfunction

  function automatic logic op_known(input logic [4:0] op);
    return op <= OP_HALT;
  endfunction

  // Ops that name a destination register (and therefore write back).
  function automatic logic op_uses_rd(input logic [4:0] op);
    return (op == OP_MOV) || (op == OP_CLR) || (op == OP_LDI) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_reads_rd(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_reads_rs(input logic [4:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/decode_execute_pipe_if.sv
// Instruction handshake plus result/redirect outputs of the decode/execute pipe.
interface decode_execute_pipe_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            res_valid;
  logic [4:0]      res_rd;
  logic [XLEN-1:0] res_data;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output in_valid, in_instr,
    input  in_ready, res_valid, res_rd, res_data, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, res_valid, res_rd, res_data, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/dex_regfile.sv
// NREG x XLEN register file: two write-first async reads, one debug read, one write.
module dex_regfile
  import dex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [4:0]      rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && idx_ok(wr_addr, NREG)) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Out-of-range indices read as zero; a matching write in flight wins.
  always_comb begin
    ra_data  = '0;
    rb_data  = '0;
    dbg_data = '0;
    if (idx_ok(ra_addr, NREG))
      ra_data = (wr_en && wr_addr == ra_addr) ? wr_data : regs[ra_addr[AW-1:0]];
    if (idx_ok(rb_addr, NREG))
      rb_data = (wr_en && wr_addr == rb_addr) ? wr_data : regs[rb_addr[AW-1:0]];
    if (idx_ok(dbg_addr, NREG))
      dbg_data = regs[dbg_addr[AW-1:0]];
  end

endmodule

// File: rtl/decode_execute_pipe.sv
// Two-stage decode/execute core with register file and registered writeback.
// Optional DEX_BYPASS_EN: forward execute result to operands instead of stalling on hazards.
module decode_execute_pipe
  import dex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int PC_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  decode_execute_pipe_if.slave  bus,
  output logic                  illegal,
  output logic                  halted,
  input  logic [4:0]            dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  dex_instr_t      in_dec, d_instr;
  logic            d_valid, run;
  logic [XLEN-1:0] d_opa, d_opb;
  logic [XLEN-1:0] rf_a, rf_b, opa_next, opb_next, exec_data;
  logic            d_bad, wr_en, jmp_go, hazard, stall, in_ready, accept;

  logic            res_valid_q, redirect_valid_q;
  logic [4:0]      res_rd_q;
  logic [XLEN-1:0] res_data_q;
  logic [PC_W-1:0] redirect_pc_q;

  assign in_dec = dex_decode(bus.in_instr);

  dex_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (in_dec.rd),
    .ra_data  (rf_a),
    .rb_addr  (in_dec.rs),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (wr_en),
    .wr_addr  (d_instr.rd),
    .wr_data  (exec_data)
  );

  always_comb begin
    d_bad = !op_known(d_instr.opcode) ||
            (op_uses_rd(d_instr.opcode)  && !idx_ok(d_instr.rd, NREG)) ||
            (op_reads_rs(d_instr.opcode) && !idx_ok(d_instr.rs, NREG));
    exec_data = '0;
    case (d_instr.opcode)
      OP_MOV:  exec_data = d_opb;
      OP_CLR:  exec_data = '0;
      OP_LDI:  exec_data = XLEN'(sext_imm(d_instr.imm));
      OP_ADD:  exec_data = d_opa + d_opb;
      OP_SUB:  exec_data = d_opa - d_opb;
      default: exec_data = '0;
    endcase
    wr_en  = d_valid && op_uses_rd(d_instr.opcode) && !d_bad;
    jmp_go = d_valid && (d_instr.opcode == OP_JMP) && !d_bad;
  end

  // Incoming op reads the register the op in D is about to write.
  assign hazard = wr_en &&
                  ((op_reads_rs(in_dec.opcode) && in_dec.rs == d_instr.rd) ||
                   (op_reads_rd(in_dec.opcode) && in_dec.rd == d_instr.rd));

`ifdef DEX_BYPASS_EN
  assign stall    = 1'b0;
  assign opa_next = (hazard && in_dec.rd == d_instr.rd) ? exec_data : rf_a;
  assign opb_next = (hazard && in_dec.rs == d_instr.rd) ? exec_data : rf_b;
`else
  assign stall    = hazard;
  assign opa_next = rf_a;
  assign opb_next = rf_b;
`endif

  assign in_ready = reset && run && !halted && !stall &&
                    !(d_valid && (d_instr.opcode == OP_JMP || d_instr.opcode == OP_HALT));
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run              <= 1'b0;
      d_valid          <= 1'b0;
      d_instr          <= '0;
      d_opa            <= '0;
      d_opb            <= '0;
      res_valid_q      <= 1'b0;
      res_rd_q         <= '0;
      res_data_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal          <= 1'b0;
      halted           <= 1'b0;
    end else begin
      run     <= 1'b1;
      d_valid <= accept;
      if (accept) begin
        d_instr <= in_dec;
        d_opa   <= opa_next;
        d_opb   <= opb_next;
      end
      res_valid_q <= wr_en;
      if (wr_en) begin
        res_rd_q   <= d_instr.rd;
        res_data_q <= exec_data;
      end
      redirect_valid_q <= jmp_go;
      if (jmp_go) redirect_pc_q <= d_opb[PC_W-1:0];
      illegal <= d_valid && d_bad;
      if (d_valid && d_instr.opcode == OP_HALT) halted <= 1'b1;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_rd         = res_rd_q;
  assign bus.res_data       = res_data_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Randomized + directed bench for decode_execute_pipe against a sequential ISA model.
module tb_decode_execute_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 8;
  localparam int PC_W = 5;

  typedef struct packed {
    logic            res;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            redir;
    logic [PC_W-1:0] pc;
    logic            ill;
    logic            halt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            illegal, halted;
  logic [4:0]      dbg_addr = '0;
  logic [XLEN-1:0] dbg_data;

  decode_execute_pipe_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  decode_execute_pipe #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .illegal  (illegal),
    .halted   (halted),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] mreg [32];
  logic            m_halted = 1'b0;
  exp_t            pend = '0;
  logic            last_ready, last_acc;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  // Architectural effect of one instruction, applied in program order.
  task automatic modelExec(input logic [31:0] instr, output exp_t e);
    int              op, rd, rs;
    logic [16:0]     imm;
    logic            rd_ok, rs_ok;
    longint          v;
    logic [XLEN-1:0] val;
    op = int'(instr[31:27]); rd = int'(instr[26:22]); rs = int'(instr[21:17]);
    imm = instr[16:0];
    rd_ok = rd < NREG; rs_ok = rs < NREG;
    e = '0;
    val = '0;
    case (op)
      0: ;
      1: if (rd_ok && rs_ok) begin val = mreg[rs]; e.res = 1; end else e.ill = 1;
      2: if (rd_ok) begin val = '0; e.res = 1; end else e.ill = 1;
      3: if (rd_ok) begin
           v = imm[16] ? longint'(imm) - 131072 : longint'(imm);
           val = v[XLEN-1:0];
           e.res = 1;
         end else e.ill = 1;
      4: if (rd_ok && rs_ok) begin val = mreg[rd] + mreg[rs]; e.res = 1; end else e.ill = 1;
      5: if (rd_ok && rs_ok) begin val = mreg[rd] - mreg[rs]; e.res = 1; end else e.ill = 1;
      6: if (rs_ok) begin e.redir = 1; e.pc = mreg[rs][PC_W-1:0]; end else e.ill = 1;
      7: e.halt = 1;
      default: e.ill = 1;
    endcase
    if (e.res) begin
      e.rd = 5'(rd);
      e.data = val;
      mreg[rd] = val;
    end
  endtask

  // One clock cycle: drive, note acceptance, then check the op that left D on this edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr);
    exp_t cur;
    logic rst_at_edge;
    bus.in_valid = valid;
    bus.in_instr = instr;
    #1;
    rst_at_edge = reset;
    last_ready = bus.in_ready;
    last_acc = valid && (bus.in_ready === 1'b1) && rst_at_edge;
    cur = pend;
    if (last_acc) modelExec(instr, pend);
    else pend = '0;
    if (!rst_at_edge) begin
      cur = '0;
      pend = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end
    @(posedge clk);
    #1;
    if (!rst_at_edge) m_halted = 1'b0;
    else if (cur.halt) m_halted = 1'b1;
    checkOutput("res_valid", bus.res_valid, cur.res);
    if (cur.res) begin
      checkOutput("res_rd", bus.res_rd, cur.rd);
      checkOutput("res_data", bus.res_data, cur.data);
    end
    checkOutput("redirect_valid", bus.redirect_valid, cur.redir);
    if (cur.redir) checkOutput("redirect_pc", bus.redirect_pc, cur.pc);
    checkOutput("illegal", illegal, cur.ill);
    checkOutput("halted", halted, m_halted);
  endtask

  task automatic issue(input logic [31:0] instr);
    logic done = 1'b0;
    for (int t = 0; t < 8 && !done; t++) begin
      applyStimulus(1'b1, instr);
      done = last_acc;
    end
    checkOutput("accept", done, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
  endtask

  task automatic checkReg(input string tag, input int a, input logic [XLEN-1:0] exp);
    dbg_addr = 5'(a);
    #1;
    checkOutput(tag, dbg_data, exp);
  endtask

  // Ten 1ns steps so the sweep ends just after a clock edge.
  task automatic checkRegs();
    for (int a = 0; a < 10; a++) begin
      dbg_addr = 5'(a);
      #1;
      checkOutput("dbg_sweep", dbg_data, (a < NREG) ? mreg[a] : '0);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkOutput("rst_ready", last_ready, 0);
    reset = 1'b1;
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkOutput("post_rst_ready", last_ready, 1);
  endtask

  initial begin
    int op, r;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;

    doReset();
    checkRegs();

    $display("[TB] LDI sign extension");
    issue(mk(3, 1, 0, 5));
    issue(mk(3, 2, 0, -3));
    idle(2);
    checkReg("t1_r2", 2, 32'hFFFF_FFFD);
    checkReg("t1_r1", 1, 32'd5);

    $display("[TB] back-to-back dependent ADD");
    issue(mk(3, 1, 0, 7));
    applyStimulus(1'b1, mk(4, 1, 1, 0));
`ifdef DEX_BYPASS_EN
    checkOutput("t2_ready", last_ready, 1);
`else
    checkOutput("t2_ready", last_ready, 0);
`endif
    if (!last_acc) issue(mk(4, 1, 1, 0));
    idle(2);
    checkReg("t2_r1", 1, 32'd14);

    $display("[TB] wraparound");
    issue(mk(3, 3, 0, -1));
    issue(mk(3, 4, 0, 1));
    issue(mk(4, 3, 4, 0));
    issue(mk(5, 3, 4, 0));
    idle(2);
    checkReg("t3_r3", 3, 32'hFFFF_FFFF);

    $display("[TB] jump");
    issue(mk(3, 5, 0, 'h13));
    issue(mk(6, 0, 5, 0));
    applyStimulus(1'b1, mk(0, 0, 0, 0));
    checkOutput("jmp_ready_low", last_ready, 0);
    issue(mk(0, 0, 0, 0));
    idle(2);

    $display("[TB] illegal forms");
    issue(mk(1, 9, 1, 0));
    issue(mk(20, 1, 1, 0));
    issue(mk(6, 0, 12, 0));
    idle(2);

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      r = $urandom_range(0, 11);
      if (r <= 6) op = r;
      else if (r == 7) op = $urandom_range(8, 31);
      else op = (r <= 9) ? 3 : 4;
      applyStimulus(($urandom_range(0, 3) != 0),
                    mk(op, $urandom_range(0, 9), $urandom_range(0, 9), int'($urandom)));
    end
    idle(2);
    checkRegs();

    $display("[TB] halt");
    issue(mk(7, 0, 0, 0));
    applyStimulus(1'b1, mk(3, 1, 0, 9));
    checkOutput("halt_ready_d", last_ready, 0);
    applyStimulus(1'b1, mk(3, 1, 0, 9));
    checkOutput("halt_ready_sticky", last_ready, 0);
    checkOutput("halt_out", halted, 1);
    idle(2);
    checkRegs();

    $display("[TB] reset mid-operation");
    doReset();
    checkOutput("halt_cleared", halted, 0);
    issue(mk(3, 1, 0, 4));
    issue(mk(3, 2, 0, 6));
    issue(mk(4, 1, 2, 0));
    reset = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("rst_mid_ready", last_ready, 0);
    applyStimulus(1'b0, '0);
    reset = 1'b1;
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkRegs();
    checkReg("rst_r1", 1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
